// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter sharing one main-memory handshake
// interface between the instruction cache (port 0) and the data cache (port 1).
//
// A grant is issued only from idle and held for a whole transaction. A write
// ends when memory accepts the request. A read ends when the granted port
// accepts the response. Only the granted port sees memory's ready, response
// valid and data. All memory-side ready/valid paths are combinational.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req_valid/req_write/req_addr/req_wdata  per-port request from the caches
//   req_ready       per-port request accepted (granted port only)
//   resp_valid      per-port read data valid (granted port only)
//   resp_ready      per-port ready for read data
//   resp_rdata      read data shared by both ports
//   req_valid_mem, read_en_mem, write_en_mem, addr_mem, wdata_mem
//                   request towards memory
//   req_ready_mem   memory accepts request
//   resp_valid_mem, rdata_mem  read response from memory
//   resp_ready_mem  arbiter ready for memory data
//   grant_id        currently or most recently granted port
//   busy            a transaction is in progress
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req_valid,
  input  logic [1:0]                  req_write,
  input  logic [1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [1:0]                  req_ready,
  output logic [1:0]                  resp_valid,
  input  logic [1:0]                  resp_ready,
  output logic [DATA_WIDTH-1:0]       resp_rdata,
  output logic                        req_valid_mem,
  input  logic                        req_ready_mem,
  output logic                        read_en_mem,
  output logic                        write_en_mem,
  output logic [ADDR_WIDTH-1:0]       addr_mem,
  output logic [DATA_WIDTH-1:0]       wdata_mem,
  input  logic                        resp_valid_mem,
  output logic                        resp_ready_mem,
  input  logic [DATA_WIDTH-1:0]       rdata_mem,
  output logic                        grant_id,
  output logic                        busy
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   op_write_q, op_write_d;
  logic   last_q, last_d;

  logic   any_req;
  logic   winner;
  logic   sel_req_valid;
  logic   req_fire;
  logic   resp_fire;

  // On a tie the port that was not granted last time wins; otherwise the
  // single requester wins.
  always_comb begin
    any_req = |req_valid;
    if (req_valid == 2'b11) begin
      winner = ~last_q;
    end else begin
      winner = req_valid[1];
    end
  end

  assign sel_req_valid = req_valid[grant_q];
  assign req_fire      = sel_req_valid & req_ready_mem;
  assign resp_fire     = resp_valid_mem & resp_ready[grant_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      op_write_q <= 1'b0;
      // Port 0 wins the first tie after reset.
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      op_write_q <= op_write_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    op_write_d     = op_write_q;
    last_d         = last_q;
    req_valid_mem  = 1'b0;
    read_en_mem    = 1'b0;
    write_en_mem   = 1'b0;
    addr_mem       = '0;
    wdata_mem      = '0;
    req_ready      = 2'b00;
    resp_valid     = 2'b00;
    resp_ready_mem = 1'b0;
    resp_rdata     = '0;

    case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d    = winner;
          last_d     = winner;
          op_write_d = req_write[winner];
          state_d    = StReq;
        end
      end

      StReq: begin
        req_valid_mem      = sel_req_valid;
        read_en_mem        = sel_req_valid & ~op_write_q;
        write_en_mem       = sel_req_valid & op_write_q;
        addr_mem           = req_addr[grant_q];
        wdata_mem          = req_wdata[grant_q];
        req_ready[grant_q] = req_ready_mem;
        // A dropped req_valid keeps the grant; only the handshake releases it.
        if (req_fire) begin
          state_d = op_write_q ? StIdle : StResp;
        end
      end

      StResp: begin
        resp_ready_mem      = resp_ready[grant_q];
        resp_valid[grant_q] = resp_valid_mem;
        resp_rdata          = rdata_mem;
        if (resp_fire) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;

  typedef logic [DW-1:0] word_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][DW-1:0]  req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [DW-1:0]       resp_rdata;
  logic                req_valid_mem;
  logic                req_ready_mem;
  logic                read_en_mem;
  logic                write_en_mem;
  logic [AW-1:0]       addr_mem;
  logic [DW-1:0]       wdata_mem;
  logic                resp_valid_mem;
  logic                resp_ready_mem;
  logic [DW-1:0]       rdata_mem;
  logic                grant_id;
  logic                busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .req_valid_mem (req_valid_mem),
    .req_ready_mem (req_ready_mem),
    .read_en_mem   (read_en_mem),
    .write_en_mem  (write_en_mem),
    .addr_mem      (addr_mem),
    .wdata_mem     (wdata_mem),
    .resp_valid_mem(resp_valid_mem),
    .resp_ready_mem(resp_ready_mem),
    .rdata_mem     (rdata_mem),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: which port owns the memory (-1 = nobody), whether the
  // owner is still waiting for read data, and the round-robin history.
  int owner;
  bit want_data;
  bit wr_m;
  bit grant_m;
  bit last_m;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner     = -1;
    want_data = 1'b0;
    wr_m      = 1'b0;
    grant_m   = 1'b0;
    last_m    = 1'b1;
  endtask

  // Compare every output against what the model says for the current inputs.
  task automatic model_check();
    logic          e_rvm;
    logic          e_rrm;
    logic [1:0]    e_rdy;
    logic [1:0]    e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_rd;
    e_rvm  = 1'b0;
    e_rrm  = 1'b0;
    e_rdy  = 2'b00;
    e_rv   = 2'b00;
    e_addr = '0;
    e_wd   = '0;
    e_rd   = '0;
    if (owner >= 0 && !want_data) begin
      e_rvm        = req_valid[owner];
      e_addr       = req_addr[owner];
      e_wd         = req_wdata[owner];
      e_rdy[owner] = req_ready_mem;
    end else if (owner >= 0) begin
      e_rrm       = resp_ready[owner];
      e_rv[owner] = resp_valid_mem;
      e_rd        = rdata_mem;
    end
    chk("req_valid_mem", word_t'(req_valid_mem), word_t'(e_rvm));
    chk("read_en_mem", word_t'(read_en_mem), word_t'(e_rvm & ~wr_m));
    chk("write_en_mem", word_t'(write_en_mem), word_t'(e_rvm & wr_m));
    chk("addr_mem", word_t'(addr_mem), word_t'(e_addr));
    chk("wdata_mem", wdata_mem, e_wd);
    chk("req_ready", word_t'(req_ready), word_t'(e_rdy));
    chk("resp_valid", word_t'(resp_valid), word_t'(e_rv));
    chk("resp_ready_mem", word_t'(resp_ready_mem), word_t'(e_rrm));
    chk("resp_rdata", resp_rdata, e_rd);
    chk("grant_id", word_t'(grant_id), word_t'(grant_m));
    chk("busy", word_t'(busy), word_t'(owner >= 0));
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int w;
    if (owner < 0) begin
      if (req_valid != 2'b00) begin
        if (req_valid == 2'b11) w = last_m ? 0 : 1;
        else w = req_valid[1] ? 1 : 0;
        owner     = w;
        last_m    = (w == 1);
        grant_m   = (w == 1);
        wr_m      = req_write[w];
        want_data = 1'b0;
      end
    end else if (!want_data) begin
      if (req_valid[owner] && req_ready_mem) begin
        if (wr_m) owner = -1;
        else want_data = 1'b1;
      end
    end else if (resp_valid_mem && resp_ready[owner]) begin
      owner     = -1;
      want_data = 1'b0;
    end
  endtask

  // Caller sets inputs just after a rising edge; this checks, then clocks.
  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    model_check();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    req_valid      = 2'b00;
    req_write      = 2'b00;
    req_addr       = '0;
    req_wdata      = '0;
    resp_ready     = 2'b00;
    req_ready_mem  = 1'b0;
    resp_valid_mem = 1'b0;
    rdata_mem      = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    model_reset();
    #1;
    rst = 1'b1;
    #1;
    model_check();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write on port 1.
    req_valid     = 2'b10;
    req_write     = 2'b10;
    req_addr[1]   = 32'h40;
    req_wdata[1]  = {16{8'hA5}};
    req_ready_mem = 1'b1;
    cycle();
    #1;
    chk("wr_write_en", word_t'(write_en_mem), word_t'(1'b1));
    chk("wr_addr", word_t'(addr_mem), word_t'(32'h40));
    chk("wr_req_ready", word_t'(req_ready), word_t'(2'b10));
    cycle();
    req_valid = 2'b00;
    #1;
    chk("wr_done_busy", word_t'(busy), word_t'(1'b0));
    chk("wr_done_ready", word_t'(req_ready), word_t'(2'b00));
    chk("wr_no_resp", word_t'(resp_valid), word_t'(2'b00));
    cycle();

    // Read on port 0 with request and response stalls.
    req_valid     = 2'b01;
    req_write     = 2'b00;
    req_addr[0]   = 32'h100;
    req_ready_mem = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rd_stall_read_en", word_t'(read_en_mem), word_t'(1'b1));
      cycle();
    end
    req_ready_mem = 1'b1;
    #1;
    chk("rd_accept_ready", word_t'(req_ready), word_t'(2'b01));
    cycle();
    req_valid     = 2'b00;
    req_ready_mem = 1'b0;
    resp_ready    = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rd_wait_resp", word_t'(resp_valid), word_t'(2'b00));
      cycle();
    end
    resp_valid_mem = 1'b1;
    rdata_mem      = 128'h1234;
    #1;
    chk("rd_resp_valid", word_t'(resp_valid), word_t'(2'b01));
    chk("rd_rdata", resp_rdata, word_t'(128'h1234));
    cycle();
    resp_valid_mem = 1'b0;
    #1;
    chk("rd_done_busy", word_t'(busy), word_t'(1'b0));

    // Reset in the middle of a port 1 read response.
    req_valid     = 2'b10;
    req_write     = 2'b00;
    req_ready_mem = 1'b1;
    cycle();
    #1;
    chk("rst_grant1", word_t'(grant_id), word_t'(1'b1));
    cycle();
    req_valid      = 2'b00;
    resp_valid_mem = 1'b1;
    resp_ready     = 2'b10;
    #1;
    chk("rst_pre_resp", word_t'(resp_valid), word_t'(2'b10));
    do_reset();

    // Continuous tie: grants alternate starting with port 0.
    req_valid      = 2'b11;
    req_write      = 2'b00;
    req_ready_mem  = 1'b1;
    resp_valid_mem = 1'b1;
    resp_ready     = 2'b11;
    rdata_mem      = {4{$urandom}};
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("tie_idle_gap", word_t'(busy), word_t'(1'b0));
      cycle();
      #1;
      chk("tie_grant", word_t'(grant_id), word_t'(t % 2));
      cycle();
      #1;
      chk("tie_resp", word_t'(resp_valid), word_t'((t % 2) == 1 ? 2'b10 : 2'b01));
      cycle();
    end

    // Response backpressure from port 1.
    req_valid      = 2'b10;
    resp_valid_mem = 1'b0;
    resp_ready     = 2'b00;
    cycle();
    cycle();
    req_valid      = 2'b00;
    resp_valid_mem = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_ready_mem", word_t'(resp_ready_mem), word_t'(1'b0));
      chk("bp_busy", word_t'(busy), word_t'(1'b1));
      cycle();
    end
    resp_ready = 2'b10;
    #1;
    chk("bp_release", word_t'(resp_ready_mem), word_t'(1'b1));
    cycle();
    resp_valid_mem = 1'b0;
    #1;
    chk("bp_done_busy", word_t'(busy), word_t'(1'b0));

    // Spurious memory response while idle.
    resp_valid_mem = 1'b1;
    resp_ready     = 2'b11;
    #1;
    chk("spur_resp_valid", word_t'(resp_valid), word_t'(2'b00));
    cycle();
    #1;
    chk("spur_busy", word_t'(busy), word_t'(1'b0));
    chk("spur_grant", word_t'(grant_id), word_t'(1'b1));

    // Random traffic against the model, with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      req_valid      = 2'($urandom_range(0, 3));
      req_write      = 2'($urandom_range(0, 3));
      req_addr[0]    = $urandom;
      req_addr[1]    = $urandom;
      req_wdata[0]   = {4{$urandom}};
      req_wdata[1]   = {4{$urandom}};
      req_ready_mem  = ($urandom_range(0, 2) != 0);
      resp_valid_mem = ($urandom_range(0, 1) != 0);
      resp_ready     = 2'($urandom_range(0, 3));
      rdata_mem      = {4{$urandom}};
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
